// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg
// Shared types and constants for the UART receive monitor.
//   rx_state_t   : receiver FSM states
//   DATA_BITS    : payload bits per frame (8N1)
//   timer_width(): width of the down-counting bit timer for a given
//                  CLKS_PER_BIT; one spare bit keeps reload values in range
package uart_rx_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  function automatic int timer_width(input int clks_per_bit);
    return $clog2(clks_per_bit) + 1;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// Small synchronous FIFO with registered storage and no fall-through:
// a pushed word becomes visible on dout the cycle after the push.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   push, din     : write request and data; dropped when full unless a pop
//                   is accepted in the same cycle
//   full          : occupancy == DEPTH
//   pop           : read request; ignored when empty
//   dout          : head-of-FIFO word (stable until popped)
//   empty         : occupancy == 0
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign dout  = mem_q[rd_ptr_q];

  // A pop frees the slot the simultaneous push needs, so a full FIFO
  // still accepts a write when it is being read in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/uart_rx_monitor.sv
// uart_rx_monitor
// Oversampling 8N1 UART receiver feeding a byte FIFO with a valid/ready
// output stream. Reports framing errors and FIFO overruns.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_rx         : asynchronous serial input, idle high
//   o_data       : head-of-FIFO byte
//   o_valid      : FIFO non-empty
//   i_ready      : consumer pops on o_valid && i_ready
//   o_frame_err  : one-cycle pulse when a stop bit is sampled low
//   o_overrun    : sticky, set when a received byte is dropped (FIFO full)
//   i_clr        : synchronous clear of o_overrun and o_rx_count
//   o_rx_count   : saturating count of bytes accepted into the FIFO
module uart_rx_monitor
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_rx,
  output logic [7:0]  o_data,
  output logic        o_valid,
  input  logic        i_ready,
  output logic        o_frame_err,
  output logic        o_overrun,
  input  logic        i_clr,
  output logic [15:0] o_rx_count
);

  localparam int TW = timer_width(CLKS_PER_BIT);
  localparam logic [TW-1:0] HALF_RELOAD = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_RELOAD = TW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_BIT    = 3'(DATA_BITS - 1);

  // Two-flop synchronizer; resets to the idle (high) line level so a
  // reset release never looks like a start edge.
  logic [1:0] sync_q, sync_d;
  logic       rx_s;

  rx_state_t            state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic [15:0]          rx_count_q, rx_count_d;
  logic [15:0]          count_base;

  logic push;
  logic fifo_full;
  logic fifo_empty;
  logic overrun_evt;
  logic push_accepted;

  assign sync_d = {sync_q[0], i_rx};
  assign rx_s   = sync_q[1];

  // Receiver FSM: timer counts down to 0 and the line is sampled on the
  // cycle the timer reads 0.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    push        = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          timer_d = HALF_RELOAD;
        end
      end
      START: begin
        if (timer_q == '0) begin
          if (rx_s) begin
            // Line back high at mid start bit: treat as a glitch.
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            bit_idx_d = '0;
            timer_d   = FULL_RELOAD;
          end
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      DATA: begin
        if (timer_q == '0) begin
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          timer_d = FULL_RELOAD;
          if (bit_idx_q == LAST_BIT) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      STOP: begin
        if (timer_q == '0) begin
          if (rx_s) begin
            push    = 1'b1;
            state_d = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_IDLE;
          end
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      WAIT_IDLE: begin
        // Hold off until the line returns high so a break is not decoded
        // as a stream of 0x00 bytes.
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Overrun only when full with no pop this cycle; the FIFO accepts the
  // push if a pop makes room.
  assign overrun_evt   = push && fifo_full && !i_ready;
  assign push_accepted = push && !overrun_evt;

  always_comb begin
    // Clear takes effect first so a push in the same cycle counts as 1.
    count_base = i_clr ? 16'h0000 : rx_count_q;
    rx_count_d = count_base;
    if (push_accepted && (count_base != 16'hFFFF)) begin
      rx_count_d = count_base + 16'h0001;
    end
    overrun_d = overrun_evt ? 1'b1 : (i_clr ? 1'b0 : overrun_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= 2'b11;
      state_q     <= IDLE;
      timer_q     <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      rx_count_q  <= '0;
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      timer_q     <= timer_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      rx_count_q  <= rx_count_d;
    end
  end

  uart_rx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (shift_q),
    .full  (fifo_full),
    .pop   (i_ready),
    .dout  (o_data),
    .empty (fifo_empty)
  );

  assign o_valid     = !fifo_empty;
  assign o_frame_err = frame_err_q;
  assign o_overrun   = overrun_q;
  assign o_rx_count  = rx_count_q;

endmodule

// File: tb/tb_uart_rx_monitor.sv
// tb_uart_rx_monitor
// Directed self-checking bench for uart_rx_monitor with CLKS_PER_BIT = 8
// and FIFO_DEPTH = 4. A negedge monitor records popped bytes, o_valid
// rising edges and o_frame_err pulses; each test compares against
// hand-computed expectations.
module tb_uart_rx_monitor;

  localparam int CPB   = 8;
  localparam int DEPTH = 4;
  // 2 synchronizer cycles + 1 IDLE decode cycle + half bit + 9 full bits
  localparam int RISE_LAT = 3 + CPB / 2 + 9 * CPB;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_rx = 1'b1;
  logic        i_ready = 1'b0;
  logic        i_clr = 1'b0;
  logic [7:0]  o_data;
  logic        o_valid;
  logic        o_frame_err;
  logic        o_overrun;
  logic [15:0] o_rx_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t_start = 0;

  // Monitor state (written only by the monitor process)
  logic [7:0] rx_q[$];
  int         fe_cnt = 0;
  int         rise_cnt = 0;
  int         last_rise = -1;
  logic       prev_valid = 1'b0;

  uart_rx_monitor #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_rx        (i_rx),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_frame_err (o_frame_err),
    .o_overrun   (o_overrun),
    .i_clr       (i_clr),
    .o_rx_count  (o_rx_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_frame_err) fe_cnt++;
    if (o_valid && !prev_valid) begin
      rise_cnt++;
      last_rise = cyc;
    end
    prev_valid = o_valid;
    if (o_valid && i_ready) begin
      rx_q.push_back(o_data);
      $display("[%0d] popped byte %02h", cyc, o_data);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_clr();
    i_clr = 1'b1;
    tick(1);
    i_clr = 1'b0;
  endtask

  // Sends one frame. pop_at_push raises i_ready only for the cycle in
  // which the receiver samples the stop bit and pushes.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input logic pop_at_push);
    t_start = cyc;
    $display("[%0d] send byte %02h stop=%0b", cyc, b, stop_bit);
    i_rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      i_rx = b[i];
      tick(CPB);
    end
    i_rx = stop_bit;
    for (int c = 0; c < CPB; c++) begin
      if (pop_at_push && c == RISE_LAT - 1 - 9 * CPB) i_ready = 1'b1;
      if (pop_at_push && c == RISE_LAT - 9 * CPB) i_ready = 1'b0;
      tick(1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(2);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", o_valid); end
    checks++; if (o_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", o_data); end
    checks++; if (o_frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b exp 0", o_frame_err); end
    checks++; if (o_overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", o_overrun); end
    checks++; if (o_rx_count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", o_rx_count); end
    #2 rst_n = 1'b1;
    tick(4);
  endtask

  task automatic test_basic();
    int base;
    base = rx_q.size();
    i_ready = 1'b1;
    send_frame(8'h55, 1'b1, 1'b0);
    checks++; if (last_rise - t_start !== RISE_LAT) begin errors++; $display("FAIL basic_lat0 got %0d exp %0d", last_rise - t_start, RISE_LAT); end
    send_frame(8'hA3, 1'b1, 1'b0);
    checks++; if (last_rise - t_start !== RISE_LAT) begin errors++; $display("FAIL basic_lat1 got %0d exp %0d", last_rise - t_start, RISE_LAT); end
    tick(4);
    checks++; if (rx_q.size() - base !== 2) begin errors++; $display("FAIL basic_nbytes got %0d exp 2", rx_q.size() - base); end
    checks++; if ((rx_q.size() > base ? rx_q[base] : 8'hxx) !== 8'h55) begin errors++; $display("FAIL basic_byte0 got %h exp 55", (rx_q.size() > base ? rx_q[base] : 8'hxx)); end
    checks++; if ((rx_q.size() > base + 1 ? rx_q[base+1] : 8'hxx) !== 8'hA3) begin errors++; $display("FAIL basic_byte1 got %h exp a3", (rx_q.size() > base + 1 ? rx_q[base+1] : 8'hxx)); end
    checks++; if (o_rx_count !== 16'd2) begin errors++; $display("FAIL basic_count got %0d exp 2", o_rx_count); end
    checks++; if (fe_cnt !== 0 || o_overrun !== 1'b0) begin errors++; $display("FAIL basic_noerr got fe=%0d ovr=%b exp 0 0", fe_cnt, o_overrun); end
  endtask

  task automatic test_glitch();
    int base, fe0, r0;
    pulse_clr();
    base = rx_q.size(); fe0 = fe_cnt; r0 = rise_cnt;
    $display("[%0d] glitch low 3 cycles", cyc);
    i_rx = 1'b0;
    tick(3);
    i_rx = 1'b1;
    tick(40);
    checks++; if (rise_cnt - r0 !== 0 || rx_q.size() !== base) begin errors++; $display("FAIL glitch_valid got rises=%0d exp 0", rise_cnt - r0); end
    checks++; if (fe_cnt - fe0 !== 0) begin errors++; $display("FAIL glitch_frame_err got %0d exp 0", fe_cnt - fe0); end
    checks++; if (o_rx_count !== 16'd0) begin errors++; $display("FAIL glitch_count got %0d exp 0", o_rx_count); end
  endtask

  task automatic test_frame_err();
    int base, fe0, r0;
    base = rx_q.size(); fe0 = fe_cnt; r0 = rise_cnt;
    send_frame(8'h41, 1'b0, 1'b0);
    tick(40);
    i_rx = 1'b1;
    tick(10);
    checks++; if (fe_cnt - fe0 !== 1) begin errors++; $display("FAIL frame_err_pulses got %0d exp 1", fe_cnt - fe0); end
    checks++; if (rise_cnt - r0 !== 0 || o_rx_count !== 16'd0) begin errors++; $display("FAIL frame_err_nopush got rises=%0d count=%0d exp 0 0", rise_cnt - r0, o_rx_count); end
    send_frame(8'h42, 1'b1, 1'b0);
    tick(4);
    checks++; if ((rx_q.size() == base + 1 ? rx_q[base] : 8'hxx) !== 8'h42) begin errors++; $display("FAIL frame_err_next got %h size %0d exp 42", (rx_q.size() > base ? rx_q[base] : 8'hxx), rx_q.size() - base); end
    checks++; if (o_rx_count !== 16'd1 || fe_cnt - fe0 !== 1) begin errors++; $display("FAIL frame_err_after got count=%0d fe=%0d exp 1 1", o_rx_count, fe_cnt - fe0); end
  endtask

  task automatic test_overrun();
    int base;
    logic [7:0] got;
    pulse_clr();
    i_ready = 1'b0;
    base = rx_q.size();
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0);
    checks++; if (o_overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b exp 1", o_overrun); end
    checks++; if (o_rx_count !== 16'd4) begin errors++; $display("FAIL ovr_count got %0d exp 4", o_rx_count); end
    checks++; if (o_valid !== 1'b1 || o_data !== 8'h01) begin errors++; $display("FAIL ovr_head got v=%b d=%h exp 1 01", o_valid, o_data); end
    i_ready = 1'b1;
    tick(8);
    i_ready = 1'b0;
    checks++; if (rx_q.size() - base !== 4) begin errors++; $display("FAIL ovr_drain_n got %0d exp 4", rx_q.size() - base); end
    for (int i = 0; i < 4; i++) begin
      got = (rx_q.size() > base + i) ? rx_q[base+i] : 8'hxx;
      checks++; if (got !== 8'(i + 1)) begin errors++; $display("FAIL ovr_drain[%0d] got %h exp %h", i, got, 8'(i + 1)); end
    end
    pulse_clr();
    checks++; if (o_overrun !== 1'b0 || o_rx_count !== 16'd0) begin errors++; $display("FAIL ovr_clr got ovr=%b count=%0d exp 0 0", o_overrun, o_rx_count); end
  endtask

  task automatic test_full_pop();
    int base;
    logic [7:0] got;
    i_ready = 1'b0;
    base = rx_q.size();
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 1'b0);
    send_frame(8'h05, 1'b1, 1'b1);
    checks++; if (o_overrun !== 1'b0) begin errors++; $display("FAIL fullpop_ovr got %b exp 0", o_overrun); end
    checks++; if (o_rx_count !== 16'd5) begin errors++; $display("FAIL fullpop_count got %0d exp 5", o_rx_count); end
    checks++; if (o_valid !== 1'b1 || o_data !== 8'h02) begin errors++; $display("FAIL fullpop_head got v=%b d=%h exp 1 02", o_valid, o_data); end
    i_ready = 1'b1;
    tick(8);
    i_ready = 1'b0;
    checks++; if (rx_q.size() - base !== 5) begin errors++; $display("FAIL fullpop_n got %0d exp 5", rx_q.size() - base); end
    for (int i = 0; i < 5; i++) begin
      got = (rx_q.size() > base + i) ? rx_q[base+i] : 8'hxx;
      checks++; if (got !== 8'(i + 1)) begin errors++; $display("FAIL fullpop_order[%0d] got %h exp %h", i, got, 8'(i + 1)); end
    end
  endtask

  task automatic test_reset_mid();
    int base;
    logic [7:0] b;
    b = 8'h7E;
    base = rx_q.size();
    i_ready = 1'b1;
    $display("[%0d] partial byte 7e then reset", cyc);
    i_rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 3; i++) begin
      i_rx = b[i];
      tick(CPB);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (o_rx_count !== 16'd0) begin errors++; $display("FAIL rstmid_count got %0d exp 0", o_rx_count); end
    checks++; if (o_valid !== 1'b0 || o_data !== 8'h00 || o_frame_err !== 1'b0 || o_overrun !== 1'b0) begin errors++; $display("FAIL rstmid_outs got v=%b d=%h fe=%b ovr=%b exp 0", o_valid, o_data, o_frame_err, o_overrun); end
    i_rx = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(3);
    send_frame(8'h33, 1'b1, 1'b0);
    tick(4);
    checks++; if ((rx_q.size() == base + 1 ? rx_q[base] : 8'hxx) !== 8'h33) begin errors++; $display("FAIL rstmid_byte got %h size %0d exp 33", (rx_q.size() > base ? rx_q[base] : 8'hxx), rx_q.size() - base); end
    checks++; if (o_rx_count !== 16'd1) begin errors++; $display("FAIL rstmid_count2 got %0d exp 1", o_rx_count); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_full_pop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_monitor.md
Name: uart_rx_monitor

Overview:
- Receive-side consumer of the SweRVolf UART TX line (o_uart_tx of swervolf_core) in the simulation top and on FPGA debug builds.
- Oversamples the 8N1 serial stream, reconstructs bytes, buffers them in a small FIFO, and presents them on a valid/ready byte stream for a console printer or self-checking bench.
- Flags framing errors and FIFO overruns.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); legal range ≥ 4.
- FIFO_DEPTH, 16, byte FIFO entries; power of two, ≥ 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- i_rx  in  1  serial line from o_uart_tx; asynchronous to clk; idle high
- o_data  out  8  head-of-FIFO byte
- o_valid  out  1  FIFO non-empty
- i_ready  in  1  consumer pops on o_valid && i_ready
- o_frame_err  out  1  one-cycle pulse: stop bit sampled low
- o_overrun  out  1  sticky: byte dropped because FIFO full
- i_clr  in  1  synchronous clear of o_overrun and o_rx_count
- o_rx_count  out  16  bytes pushed into FIFO; saturates at 16'hFFFF

Behaviour:
- Reset (rst_n low, asynchronous): all outputs are 0. Synchronizer flops reset to 1 (line idle). FSM goes to IDLE. FIFO pointers and count clear. Any byte in flight is discarded.
- Input: 2-flop synchronizer feeding rx_s. All timing below is relative to rx_s.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE. Bit timer is $clog2(CLKS_PER_BIT)+1 bits wide; bit index is 3 bits.
- IDLE: rx_s == 0 → START, timer loaded with CLKS_PER_BIT/2 − 1 (integer division).
- START: when timer reaches 0, sample rx_s. If 1 → IDLE (glitch rejection, nothing reported). If 0 → DATA, bit index 0, timer CLKS_PER_BIT − 1.
- DATA: at each timer expiry, shift rx_s into the shift register LSB-first and reload the timer. After bit index 7 → STOP, timer CLKS_PER_BIT − 1.
- STOP: at expiry, sample rx_s.
  - If 1: push byte → IDLE.
  - If 0: pulse o_frame_err for 1 cycle, do not push → WAIT_IDLE.
- WAIT_IDLE: stay until rx_s == 1, then → IDLE. This prevents a break condition from being decoded as 0x00 repeatedly.
- Sample points: first start-edge cycle E; start check at E + CLKS_PER_BIT/2; data bit k at E + CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT; stop bit at E + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT.
- Push latency: o_valid rises the cycle after the stop-sample cycle. No fall-through.
- FIFO:
  - Registered output; o_data is stable while o_valid && !i_ready.
  - Push while full and no pop in the same cycle → byte dropped, o_overrun set; o_rx_count does not increment.
  - Push and pop in the same cycle when full → both accepted; occupancy unchanged; no overrun.
  - Pop while empty → ignored.
- o_rx_count increments on each accepted push and saturates at 16'hFFFF.
- i_clr in the same cycle as an overrun event: set wins, so o_overrun = 1. i_clr in the same cycle as a push: count becomes 1.
- i_clr does not affect the FSM or FIFO contents.

Decomposition:
- Package uart_rx_pkg:
  - state enum rx_state_t {IDLE, START, DATA, STOP, WAIT_IDLE}
  - localparam DATA_BITS = 8
  - function for the timer width.
- Sub-module uart_rx_fifo: synchronous FIFO, parameters WIDTH and DEPTH. Ports: push/din/full, pop/dout/empty. Holds the simultaneous-push/pop-at-full rule.
- Top: synchronizer, FSM, timer, counters.

Test Plan (CLKS_PER_BIT = 8, FIFO_DEPTH = 4 unless noted):
- Send 0x55 then 0xA3 with i_ready = 1 → o_data 0x55 then 0xA3; each o_valid rises 1 cycle after its stop sample; o_rx_count = 2; no error.
- 3-cycle low glitch on idle i_rx → FSM returns to IDLE; o_valid, o_frame_err, o_rx_count remain 0.
- Send 0x41 with stop bit driven low, then hold i_rx low 40 cycles, then release → exactly one o_frame_err pulse, nothing pushed; a following 0x42 is received correctly.
- i_ready = 0, send 5 bytes 0x01..0x05 → o_overrun = 1, o_rx_count = 4; draining yields 0x01..0x04; pulsing i_clr → o_overrun = 0, o_rx_count = 0.
- FIFO full, i_ready = 1 on the cycle the 5th byte pushes → no overrun; drained order 0x01..0x05.
- Drop rst_n mid-DATA of 0x7E, release, send 0x33 → only 0x33 appears; all outputs 0 during reset.
